// File: rtl/rat_pkg.sv
// Shared types for the rat maze solver and its replay consumer: moves, grid size, player states.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package rat_pkg;

    localparam int GRID = 16;
    localparam int MAX  = GRID - 1;

    // Opcode encoding on the replay stream; each move's opposite is its bitwise complement.
    typedef enum logic [1:0] {
        MV_UP    = 2'b00,
        MV_RIGHT = 2'b01,
        MV_LEFT  = 2'b10,
        MV_DOWN  = 2'b11
    } move_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_PLAY,
        ST_CHECK,
        ST_DONE
    } play_state_t;

    // The stream runs goal-first, so walking it back to the start undoes each move.
    function automatic move_t inverse_move(input move_t m);
        return move_t'(~m);
    endfunction

endpackage

// File: rtl/path_fifo.sv
// Small synchronous FIFO holding replay opcodes between the stream and the paced walker.
// Latency: a pushed entry is poppable the cycle after the push; pop data is combinational from the head.
// Backpressure: a push while full is discarded unless a pop in the same cycle frees the slot.
module path_fifo #(
    parameter int  DEPTH = 16,
    parameter int  W     = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  pop_dat,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_dat = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointers wrap naturally because DEPTH is a power of two; clr empties in one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/rat_path_player.sv
// Replays the solver's goal-first move stream from (MAX,MAX) back to (0,0) and checks the walk.
// Latency: first step PACE cycles after the first accepted move, then at most one step per PACE cycles.
// Backpressure: none; a move arriving with the FIFO full is dropped and flagged in err_ovf.
module rat_path_player #(
    parameter int  DEPTH = 16,
    parameter int  PACE  = 4,
    parameter int  GRID  = rat_pkg::GRID,
    localparam int CW    = $clog2(GRID)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          move_valid,
    input  logic [1:0]    move_in,
    input  logic          path_end,
    output logic [CW-1:0] pos_x,
    output logic [CW-1:0] pos_y,
    output logic          pos_valid,
    output logic [7:0]    step_cnt,
    output logic          busy,
    output logic          path_ok,
    output logic          err_oob,
    output logic          err_ovf
);

    import rat_pkg::*;

    localparam int            AW      = $clog2(DEPTH);
    localparam int            PW      = (PACE > 1) ? $clog2(PACE) : 1;
    localparam logic [PW-1:0] PACE_LD = PW'(PACE - 1);
    localparam logic [CW-1:0] PMAX    = CW'(GRID - 1);

    play_state_t   state;
    play_state_t   state_nxt;
    logic [PW-1:0] pace_cnt;
    logic          end_seen;
    logic          fifo_full;
    logic          fifo_empty;
    logic [AW:0]   fifo_count;
    logic [1:0]    fifo_dat;
    logic          accepting;
    logic          arm;
    logic          step;
    logic          push;
    logic          ovf_hit;
    logic [CW-1:0] step_x;
    logic [CW-1:0] step_y;
    logic          step_oob;

    assign accepting = (state == ST_ARMED) || (state == ST_PLAY);
    assign busy      = accepting;
    assign arm       = start && ((state == ST_IDLE) || (state == ST_DONE));
    // A step pops the FIFO, so a push into a full FIFO in the same cycle still fits.
    assign step      = (state == ST_PLAY) && (pace_cnt == '0) && !fifo_empty;
    assign push      = move_valid && accepting && (!fifo_full || step);
    assign ovf_hit   = move_valid && accepting && fifo_full && !step;

    path_fifo #(
        .DEPTH (DEPTH),
        .W     (2)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (arm),
        .push     (push),
        .push_dat (move_in),
        .pop      (step),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Candidate position for the head opcode; a move off the grid keeps the old position.
    always_comb begin
        step_x   = pos_x;
        step_y   = pos_y;
        step_oob = 1'b0;
        case (inverse_move(move_t'(fifo_dat)))
            MV_UP:    if (pos_y == PMAX) step_oob = 1'b1; else step_y = pos_y + CW'(1);
            MV_RIGHT: if (pos_x == PMAX) step_oob = 1'b1; else step_x = pos_x + CW'(1);
            MV_LEFT:  if (pos_x == '0)   step_oob = 1'b1; else step_x = pos_x - CW'(1);
            MV_DOWN:  if (pos_y == '0)   step_oob = 1'b1; else step_y = pos_y - CW'(1);
            default:  step_oob = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Next state: play starts on the first move; finishes once the stream ended and the FIFO drained.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_ARMED;
            ST_ARMED: begin
                if (move_valid)    state_nxt = ST_PLAY;
                else if (path_end) state_nxt = ST_CHECK;
            end
            ST_PLAY:  if (end_seen && (fifo_count == '0) && !move_valid) state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = ST_DONE;
            ST_DONE:  if (start) state_nxt = ST_ARMED;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Pace counter, position walk, step count and the sticky error/result flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_x     <= PMAX;
            pos_y     <= PMAX;
            pos_valid <= 1'b0;
            step_cnt  <= '0;
            path_ok   <= 1'b0;
            err_oob   <= 1'b0;
            err_ovf   <= 1'b0;
            end_seen  <= 1'b0;
            pace_cnt  <= '0;
        end else begin
            pos_valid <= 1'b0;
            if (arm) begin
                pos_x    <= PMAX;
                pos_y    <= PMAX;
                step_cnt <= '0;
                path_ok  <= 1'b0;
                err_oob  <= 1'b0;
                err_ovf  <= 1'b0;
                end_seen <= 1'b0;
                pace_cnt <= '0;
            end else begin
                if (accepting && path_end) end_seen <= 1'b1;
                if (ovf_hit)               err_ovf  <= 1'b1;
                if ((state == ST_ARMED) && move_valid) begin
                    pace_cnt <= PACE_LD;
                end else if (step) begin
                    pace_cnt  <= PACE_LD;
                    pos_x     <= step_x;
                    pos_y     <= step_y;
                    pos_valid <= 1'b1;
                    if (step_oob)         err_oob  <= 1'b1;
                    if (step_cnt != 8'hFF) step_cnt <= step_cnt + 8'd1;
                end else if ((state == ST_PLAY) && (pace_cnt != '0)) begin
                    pace_cnt <= pace_cnt - PW'(1);
                end
                if (state == ST_CHECK)
                    path_ok <= (pos_x == '0) && (pos_y == '0) && !err_oob && !err_ovf;
            end
        end
    end

endmodule
